// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the data-memory access unit.
// Size codes match the downstream load extension mux select.
package mem_access_unit_pkg;

    localparam logic [1:0] SIZE_WORD  = 2'd0;
    localparam logic [1:0] SIZE_HALF  = 2'd1;
    localparam logic [1:0] SIZE_BYTE  = 2'd2;
    localparam logic [1:0] SIZE_WORD3 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width of the wait counter for a given timeout
    function automatic int cnt_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane steering: store replication, byte enables,
// misalignment detection and load shift-down with zero fill.
import mem_access_unit_pkg::*;

module mem_lane_align (
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o,
    input  logic [1:0]  ld_size_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] rdata_o
);

    // Store side: lane enables and replicated write data
    always_comb begin
        be_o         = 4'b1111;
        wdata_o      = wdata_i;
        misaligned_o = 1'b0;
        unique case (st_size_i)
            SIZE_HALF: begin
                be_o         = st_off_i[1] ? 4'b1100 : 4'b0011;
                wdata_o      = {2{wdata_i[15:0]}};
                misaligned_o = st_off_i[0];
            end
            SIZE_BYTE: begin
                be_o    = 4'b0001 << st_off_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            default: begin
                be_o         = 4'b1111;
                wdata_o      = wdata_i;
                misaligned_o = |st_off_i;
            end
        endcase
    end

    // Load side: shift addressed lane(s) down, zero the rest
    always_comb begin
        rdata_o = rdata_i;
        unique case (ld_size_i)
            SIZE_HALF: begin
                rdata_o = ld_off_i[1] ? {16'd0, rdata_i[31:16]}
                                      : {16'd0, rdata_i[15:0]};
            end
            SIZE_BYTE: begin
                unique case (ld_off_i)
                    2'd0:    rdata_o = {24'd0, rdata_i[7:0]};
                    2'd1:    rdata_o = {24'd0, rdata_i[15:8]};
                    2'd2:    rdata_o = {24'd0, rdata_i[23:16]};
                    default: rdata_o = {24'd0, rdata_i[31:24]};
                endcase
            end
            default: rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access unit: issues word-aligned req/ack transactions,
// stalls the pipeline while waiting, and aligns returned load data.
import mem_access_unit_pkg::*;

module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  Size,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Done,
    output logic        Misaligned,
    output logic        BusError,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [3:0]  MemByteEn,
    output logic [31:0] MemWData,
    input  logic [31:0] MemRData,
    input  logic        MemAck
);

    localparam int CW = cnt_width(TIMEOUT);

    state_e        state_q;
    logic [31:0]   rdata_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic          req_q;
    logic          we_q;
    logic          done_q;
    logic          mis_q;
    logic          berr_q;
    logic [1:0]    size_q;
    logic [1:0]    off_q;
    logic [CW-1:0] cnt_q;

    logic          op;
    logic          mis;
    logic [3:0]    be_d;
    logic [31:0]   wdata_d;
    logic [31:0]   rdata_d;
    logic          timeout_hit;

    assign op = MemRead | MemWrite;

    mem_lane_align u_align (
        .st_size_i    (Size),
        .st_off_i     (Address[1:0]),
        .wdata_i      (WriteData),
        .be_o         (be_d),
        .wdata_o      (wdata_d),
        .misaligned_o (mis),
        .ld_size_i    (size_q),
        .ld_off_i     (off_q),
        .rdata_i      (MemRData),
        .rdata_o      (rdata_d)
    );

    // Final wait cycle; a zero timeout never expires
    assign timeout_hit = (TIMEOUT != 0)
                       && (cnt_q == CW'(TIMEOUT - 1));

    // Stall rises combinationally in the issue cycle
    assign Stall = (state_q == ST_BUSY)
                 | ((state_q == ST_IDLE) & op & ~mis);

    assign ReadData   = rdata_q;
    assign Done       = done_q;
    assign Misaligned = mis_q;
    assign BusError   = berr_q;
    assign MemReq     = req_q;
    assign MemWe      = we_q;
    assign MemAddr    = addr_q;
    assign MemByteEn  = be_q;
    assign MemWData   = wdata_q;

    // Access FSM with registered memory-side and status outputs
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
            size_q  <= SIZE_WORD;
            off_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            mis_q  <= 1'b0;
            berr_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (op && mis) begin
                        mis_q <= 1'b1;
                    end else if (op) begin
                        addr_q  <= {Address[31:2], 2'b00};
                        we_q    <= ~MemRead;
                        be_q    <= be_d;
                        wdata_q <= wdata_d;
                        size_q  <= Size;
                        off_q   <= Address[1:0];
                        req_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (MemAck) begin
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_DONE;
                        if (!we_q) begin
                            rdata_q <= rdata_d;
                        end
                    end else if (timeout_hit) begin
                        req_q   <= 1'b0;
                        berr_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the EX/MEM pipeline register and the data memory.
- Turns lw/lh/lb/sw/sh/sb requests into word-aligned memory transactions with byte enables, using a req/ack handshake with variable latency.
- Stalls the pipeline until the memory responds.
- Returns load data with the addressed byte or half shifted down to bits [7:0]/[15:0] and upper bits zeroed. This output feeds the downstream load sign-extension mux directly; that mux does all sign extension.

Parameters:
- TIMEOUT, 16, max cycles waiting for MemAck before aborting with BusError; 0 disables the timeout.

Ports:
- Clk  input  1  clock, rising edge
- Rst  input  1  synchronous reset, active-high
- MemRead  input  1  load request from EX/MEM
- MemWrite  input  1  store request from EX/MEM
- Size  input  2  0=word, 1=half, 2=byte, 3=word (same encoding as the extension mux select)
- Address  input  32  byte address
- WriteData  input  32  store data, right-aligned
- ReadData  output  32  aligned load data, upper bits zero
- Stall  output  1  hold pipeline this cycle
- Done  output  1  one-cycle pulse, access complete
- Misaligned  output  1  one-cycle pulse, access rejected
- BusError  output  1  one-cycle pulse, timeout abort
- MemReq  output  1  request to memory
- MemWe  output  1  1=write
- MemAddr  output  32  {Address[31:2],2'b00}
- MemByteEn  output  4  lane enables, lane k = bits [8k+7:8k]
- MemWData  output  32  lane-replicated store data
- MemRData  input  32  memory read word
- MemAck  input  1  memory completes the request this cycle

Behaviour:
- Reset values:
  - State IDLE; ReadData=0.
  - Done, Misaligned, BusError, MemReq, MemWe = 0.
  - MemAddr=0, MemByteEn=0, MemWData=0; timeout counter=0.
- Byte order is little-endian: offset k=Address[1:0] selects lane k.
- op = MemRead|MemWrite. If both are high, read wins and no write is issued.
- Misalignment rule: half with Address[0]=1, or word/size 3 with Address[1:0]!=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - op and aligned: register MemAddr, MemWe, MemByteEn, MemWData, Size and offset; set MemReq=1; go to BUSY.
  - op and misaligned: pulse Misaligned next cycle; no memory access; stay IDLE.
  - Stall = op & ~misaligned, combinational, so it is already high in the issue cycle.
- BUSY:
  - MemReq held high; all Mem* outputs stable; Stall=1.
  - On MemAck: MemReq=0 next cycle; for reads, ReadData captures the aligned MemRData; go to DONE.
  - If TIMEOUT!=0 and TIMEOUT cycles elapse with no ack: MemReq=0, BusError pulses; ReadData unchanged; go to DONE.
- DONE:
  - Done=1 (not on the timeout path); Stall=0 so the pipeline advances.
  - Unconditionally go to IDLE.
  - The still-asserted MemRead/MemWrite of the completing instruction is ignored this cycle; no re-issue.
- Load alignment:
  - word: MemRData.
  - half: {16'd0, lane pair} — bits [15:0] if offset=0, [31:16] if offset=2.
  - byte: {24'd0, lane k}.
- Store encoding:
  - word: ByteEn 1111, WData=WriteData.
  - half: ByteEn 0011 (offset 0) or 1100 (offset 2); WData={2{WriteData[15:0]}}.
  - byte: ByteEn = 1<<offset; WData={4{WriteData[7:0]}}.
- ReadData holds its value until the next completed read; stores do not modify it.
- Rst in any state: return to IDLE with reset values; the pending transaction is dropped; a late MemAck arriving in IDLE is ignored.
- MemAck in the same cycle the timeout expires: the ack wins and is a normal completion.

Decomposition:
- Shared package holds:
  - Size encodings SIZE_WORD=0, SIZE_HALF=1, SIZE_BYTE=2, shared with the extension mux select.
  - State encodings IDLE/BUSY/DONE.
- One natural sub-module: mem_lane_align, purely combinational. It produces the load shift/zero-fill, store replication, byte enables and the misalignment flag.

Test Plan:
- Load byte: Address=0x1003, Size=2, MemRData=0x8A123456, MemAck 3 cycles after MemReq -> MemAddr=0x1000, ByteEn=1000, Stall high 4 cycles, ReadData=0x0000008A, Done pulse.
- Load half: Address=0x2002, Size=1, MemRData=0xBEEF1234, immediate ack -> ReadData=0x0000BEEF; word load at 0x2000 -> 0xBEEF1234.
- Store half: Address=0x3002, WriteData=0xFFFF5AA5 -> MemWe=1, ByteEn=1100, MemWData=0x5AA55AA5; ReadData unchanged.
- Misaligned: word at 0x4001, then half at 0x4003 -> Misaligned pulses, MemReq never asserts, Stall stays 0.
- Timeout: TIMEOUT=16, read with no ack -> MemReq drops after 16 cycles, BusError pulses, no Done; ack at cycle 16 instead -> normal Done.
- Reset mid-BUSY: assert Rst with MemReq=1 -> next cycle MemReq=0, Stall=0, ReadData=0; a subsequent stray MemAck has no effect.
